uart_rx_oversample: RTL and testbench
=====================================

# uart_rx_oversample

Majority-vote UART receiver for the serial UART datapath. Recovers 8N1 frames (optionally 8E1) from an asynchronous serial line, using the same 18-bit clocks-per-bit value the baud-rate generator supplies to the transmitter. It is the receiving end for frames sent by the UART transmitter. It adds framing, parity and overrun detection, and presents each byte through a one-entry valid/ready holding register.

## Interface
- No parameters; data width fixed at 8, stop bits fixed at 1.
- internal_clock  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- CLK_PERS_BIT  in  18  clock cycles per bit. Values below 16 are treated as 16. Sampled only in IDLE.
- RX_Enable  in  1  receiver enable. Low forces IDLE.
- RX_Data  in  1  asynchronous serial line; idles high.
- rx_byte  out  8  received byte, LSB received first.
- rx_valid  out  1  rx_byte and its status flags are valid.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready.
- rx_frame_err  out  1  stop bit sampled 0 for this byte.
- rx_parity_err  out  1  parity mismatch for this byte (0 when parity is compiled out).
- rx_overrun  out  1  sticky: at least one byte was dropped.
- rx_busy  out  1  high in any state other than IDLE.

## Operation
- RX_Data passes through a 2-flop synchroniser, both flops reset to 1. A third flop holds the previous synchronised value for edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP. An 18-bit bit counter cnt runs 0..CPB-1. half = CPB>>1.
- Each bit is sampled at cnt = half-1, half and half+1. The bit value is the 2-of-3 majority, resolved at half+1.
- IDLE: a synchronised falling edge with RX_Enable=1 latches CPB, clears cnt and enters START.
- START: if the majority is 1, the start was false; return to IDLE with no output. Otherwise, at cnt = CPB-1, go to DATA.
- DATA: shift 8 bits LSB-first, wrapping cnt after each bit. After bit 7, go to PARITY if compiled in, else to STOP.
- PARITY: compare the sampled bit with the even parity of the data bits (XOR of 8 data bits and the parity bit must be 0).
- STOP: at cnt = half+1, deliver the byte with rx_frame_err = ~majority, then go to IDLE immediately; the rest of the stop bit is not awaited.
- Frames with errors are still delivered, with their flags set.
- Because IDLE requires a falling edge, a line stuck low after a framing error does not start a new frame until it returns high.
- Holding register, on delivery:
  - rx_valid=0, or rx_valid && rx_ready in the same cycle: load byte and flags, rx_valid=1.
  - Otherwise: drop the new byte, set rx_overrun, leave the held byte unchanged.
- rx_overrun clears on the next completed handshake, unless a drop occurs in that same cycle.
- RX_Enable low mid-frame: abort to IDLE next cycle with no delivery. The holding register and rx_overrun are unaffected.
- rst_n low at any time: FSM to IDLE, cnt=0, holding register cleared.

## Timing
- Reset values: rx_byte=0x00, rx_valid=0, rx_frame_err=0, rx_parity_err=0, rx_overrun=0, rx_busy=0.
- Pin to synchronised edge: 2 cycles. The cycle that enters START counts as cnt=0.
- Delivery (no parity): rx_valid rises at cycle 9*CPB + half + 2 after the START-entry cycle. With parity: 10*CPB + half + 2.
- rx_valid falls the cycle after the handshake, unless a new byte loads in that same cycle.
- Back-to-back frames are received with no gap: the next start edge is armed about half a bit before the nominal stop-bit end.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists, the frame is 8E1, and rx_parity_err is computed.
- Not defined: the PARITY state is removed, the frame is 8N1, and rx_parity_err is tied to 0.

## Test plan
- CPB=16, send 0xA5 8N1, rx_ready=1 -> rx_byte=0xA5, rx_valid pulses 1 cycle, rx_frame_err=0, rx_valid at cycle 9*16+10 after START entry.
- 1-cycle glitch low at cnt=half on bit 3 of 0xFF -> rx_byte=0xFF (majority vote rejects the glitch). 4-cycle false start -> no delivery, back to IDLE.
- Stop bit driven 0 on 0x3C -> rx_byte=0x3C, rx_frame_err=1. Line held low 3 bit times -> no second byte until the line goes high.
- rx_ready=0, send 0x11 then 0x22 -> rx_byte stays 0x11 and rx_overrun=1. Raise rx_ready -> handshake completes, rx_overrun=0.
- UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> rx_parity_err=1. Send 0x07 with parity bit 1 -> rx_parity_err=0.
- RX_Enable dropped in DATA, and separately rst_n pulsed in DATA -> no delivery, rx_busy=0 next cycle; after rst_n, all outputs at their reset values.

Source files
------------

// File: rtl/uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// uart_rx_oversample
//
// Majority-vote UART receiver. Recovers 8N1 frames (8E1 when the macro
// UART_RX_PARITY_EN is defined) from an asynchronous serial line. The bit
// period comes from the same clocks-per-bit value that drives the transmitter.
// Each bit is sampled three times around its centre and resolved by 2-of-3
// majority. Received bytes are offered through a one-entry valid/ready
// holding register together with framing and parity status. A sticky overrun
// flag records any byte that arrived while the previous one was still held.
//
// Configuration:
//   UART_RX_PARITY_EN  defined   -> PARITY state present, frame is 8E1,
//                                   rx_parity_err reports even-parity errors.
//                      undefined -> frame is 8N1, rx_parity_err tied to 0.
//
// Ports:
//   internal_clock  in   1   system clock, rising edge
//   rst_n           in   1   asynchronous active-low reset
//   CLK_PERS_BIT    in  18   clocks per bit (values below 16 act as 16),
//                            captured when a frame starts
//   RX_Enable       in   1   receiver enable; low aborts to IDLE
//   RX_Data         in   1   asynchronous serial input, idles high
//   rx_byte         out  8   received byte, LSB first on the line
//   rx_valid        out  1   rx_byte and status flags are valid
//   rx_ready        in   1   consumer accepts when rx_valid && rx_ready
//   rx_frame_err    out  1   stop bit was sampled low
//   rx_parity_err   out  1   parity mismatch (0 without parity support)
//   rx_overrun      out  1   sticky: a byte was dropped
//   rx_busy         out  1   receiver is inside a frame
// -----------------------------------------------------------------------------
module uart_rx_oversample (
    input  logic        internal_clock,
    input  logic        rst_n,
    input  logic [17:0] CLK_PERS_BIT,
    input  logic        RX_Enable,
    input  logic        RX_Data,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_frame_err,
    output logic        rx_parity_err,
    output logic        rx_overrun,
    output logic        rx_busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    // Bit periods shorter than 16 clocks leave no room for three centred
    // samples, so they are raised to 16.
    function automatic logic [17:0] sat_cpb(input logic [17:0] v);
        return (v < 18'd16) ? 18'd16 : v;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Synchroniser and edge-detect flops.
    logic        rx_sync_p0;
    logic        rx_sync_p1;
    logic        rx_prev_p2;
    logic        fall_edge;

    // Frame control.
    state_t      state;
    state_t      state_nxt;
    logic [17:0] cnt;
    logic [17:0] cnt_nxt;
    logic [2:0]  bit_idx;
    logic [2:0]  bit_idx_nxt;
    logic        load_cpb;
    logic        deliver;

    // Per-frame datapath.
    logic [17:0] cpb_r;
    logic [17:0] half_r;
    logic        samp_a;
    logic        samp_b;
    logic        vote;
    logic        at_a;
    logic        at_b;
    logic        at_c;
    logic        at_end;
    logic [7:0]  shift_r;
`ifdef UART_RX_PARITY_EN
    logic        par_err_r;
`endif

    // Holding register control.
    logic        handshake;
    logic        accept;

    // ---- stage p0/p1: two-flop synchroniser, p2: previous value for edges
    always_ff @(posedge internal_clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_sync_p0 <= RX_Data;
            rx_sync_p1 <= rx_sync_p0;
            rx_prev_p2 <= rx_sync_p1;
        end
    end

    assign fall_edge = rx_prev_p2 & ~rx_sync_p1;

    // Sample points around the bit centre; the third sample is the live
    // synchronised value, so the vote resolves in the half+1 cycle.
    assign at_a   = (cnt == half_r - 18'd1);
    assign at_b   = (cnt == half_r);
    assign at_c   = (cnt == half_r + 18'd1);
    assign at_end = (cnt == cpb_r - 18'd1);
    assign vote   = maj3(samp_a, samp_b, rx_sync_p1);

    // ---- frame FSM: state register
    always_ff @(posedge internal_clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    // ---- frame FSM: next state and control strobes
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + 18'd1;
        bit_idx_nxt = bit_idx;
        load_cpb    = 1'b0;
        deliver     = 1'b0;

        if (!RX_Enable) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    // Requiring an edge keeps a line stuck low from
                    // retriggering frames.
                    if (fall_edge) begin
                        load_cpb  = 1'b1;
                        state_nxt = S_START;
                    end
                end
                S_START: begin
                    if (at_c && vote) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else if (at_end) begin
                        state_nxt = S_DATA;
                        cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    if (at_end) begin
                        cnt_nxt     = '0;
                        bit_idx_nxt = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = S_PARITY;
`else
                            state_nxt = S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_end) begin
                        state_nxt = S_STOP;
                        cnt_nxt   = '0;
                    end
                end
`endif
                S_STOP: begin
                    // Leave at the stop-bit centre so the next start edge
                    // can be caught without a gap.
                    if (at_c) begin
                        deliver   = 1'b1;
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign rx_busy = (state != S_IDLE);

    // ---- datapath: bit period capture, samples, shift register
    always_ff @(posedge internal_clock) begin
        if (load_cpb) begin
            cpb_r  <= sat_cpb(CLK_PERS_BIT);
            half_r <= sat_cpb(CLK_PERS_BIT) >> 1;
        end
        if (at_a) begin
            samp_a <= rx_sync_p1;
        end
        if (at_b) begin
            samp_b <= rx_sync_p1;
        end
        if ((state == S_DATA) && at_c) begin
            shift_r <= {vote, shift_r[7:1]};
        end
`ifdef UART_RX_PARITY_EN
        // Even parity: data bits and parity bit must XOR to zero.
        if ((state == S_PARITY) && at_c) begin
            par_err_r <= ^{shift_r, vote};
        end
`endif
    end

    // ---- output stage: one-entry holding register and overrun flag
    assign handshake = rx_valid && rx_ready;
    assign accept    = deliver && (!rx_valid || rx_ready);

    always_ff @(posedge internal_clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            if (accept) begin
                rx_byte      <= shift_r;
                rx_frame_err <= ~vote;
                rx_valid     <= 1'b1;
            end else if (handshake) begin
                rx_valid <= 1'b0;
            end

            if (deliver && !accept) begin
                rx_overrun <= 1'b1;
            end else if (handshake) begin
                rx_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge internal_clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_parity_err <= 1'b0;
        end else if (accept) begin
            rx_parity_err <= par_err_r;
        end
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_oversample
//
// Scoreboard bench for uart_rx_oversample. Frame-sending tasks push the
// expected byte and flags (derived from the frame's own bits) into a queue;
// a monitor pops and compares on every valid/ready handshake. Directed cases
// cover latency, glitch rejection, false start, framing error, overrun,
// parity, enable abort and reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_uart_rx_oversample;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        internal_clock = 1'b0;
    logic        rst_n;
    logic [17:0] CLK_PERS_BIT;
    logic        RX_Enable;
    logic        RX_Data;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_overrun;
    logic        rx_busy;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    uart_rx_oversample dut (
        .internal_clock (internal_clock),
        .rst_n          (rst_n),
        .CLK_PERS_BIT   (CLK_PERS_BIT),
        .RX_Enable      (RX_Enable),
        .RX_Data        (RX_Data),
        .rx_byte        (rx_byte),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_frame_err   (rx_frame_err),
        .rx_parity_err  (rx_parity_err),
        .rx_overrun     (rx_overrun),
        .rx_busy        (rx_busy)
    );

    always #5 internal_clock = ~internal_clock;

    always @(posedge internal_clock) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge internal_clock);
        #1;
    endtask

    task automatic idle(input int n);
        RX_Data = 1'b1;
        repeat (n) tick();
    endtask

    // One bit period; optionally flips the line for one clock at index g.
    task automatic send_bit(input logic v, input int cpb, input int g);
        for (int j = 0; j < cpb; j++) begin
            RX_Data = (j == g) ? ~v : v;
            tick();
        end
    endtask

    // Sends one frame. Expected result follows the frame rules: the byte as
    // sent, frame error when the stop bit is 0, parity error when data and
    // parity bit do not XOR to zero. gbit selects a data bit that gets a
    // one-clock glitch at its centre (-1 for none).
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                              input int raw_cpb, input int gbit, input bit push);
        int   cpb;
        exp_t e;
        cpb = (raw_cpb < 16) ? 16 : raw_cpb;
        e.d  = d;
        e.fe = ~stop;
        e.pe = PAR_EN ? ((^d) ^ pbit) : 1'b0;
        if (push) exp_q.push_back(e);
        CLK_PERS_BIT = 18'(raw_cpb);
        send_bit(1'b0, cpb, -1);
        for (int i = 0; i < 8; i++) send_bit(d[i], cpb, (i == gbit) ? cpb / 2 : -1);
        if (PAR_EN) send_bit(pbit, cpb, -1);
        send_bit(stop, cpb, -1);
    endtask

    // Monitor: compare every accepted byte with the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge internal_clock);
            if (rst_n === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: rx_byte=%0h arrived, none expected", rx_byte);
                end else begin
                    e = exp_q.pop_front();
                    chk("rx_byte", int'(rx_byte), int'(e.d));
                    chk("rx_frame_err", int'(rx_frame_err), int'(e.fe));
                    chk("rx_parity_err", int'(rx_parity_err), int'(e.pe));
                end
            end
        end
    end

    initial begin
        int         t0;
        int         lat_exp;
        int         raw;
        int         gbit;
        int         gap;
        int         k;
        logic [7:0] d;
        logic       stop;
        logic       pbit;

        rst_n        = 1'b0;
        RX_Data      = 1'b1;
        RX_Enable    = 1'b1;
        rx_ready     = 1'b1;
        CLK_PERS_BIT = 18'd16;
        repeat (3) tick();
        @(negedge internal_clock);
        chk("reset_rx_byte", int'(rx_byte), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_frame_err", int'(rx_frame_err), 0);
        chk("reset_parity_err", int'(rx_parity_err), 0);
        chk("reset_overrun", int'(rx_overrun), 0);
        chk("reset_busy", int'(rx_busy), 0);
        tick();
        rst_n = 1'b1;
        idle(5);

        // 0xA5 at CPB=16: 2 synchroniser cycles + 1 to enter START, then
        // 9*CPB+half+2 (one more bit with parity) to rx_valid.
        lat_exp = 9 * 16 + 8 + 5 + (PAR_EN ? 16 : 0);
        t0 = cyc;
        fork
            send_frame(8'hA5, ~(^8'hA5), 1'b1, 16, -1, 1'b1);
            begin
                k = 0;
                while (rx_valid !== 1'b1 && k < 2000) begin
                    @(negedge internal_clock);
                    k++;
                end
                chk("a5_latency", cyc - t0, lat_exp);
                @(negedge internal_clock);
                chk("a5_valid_one_cycle", int'(rx_valid), 0);
            end
        join
        idle(20);

        // Glitch on bit 3 of 0xFF is outvoted.
        send_frame(8'hFF, 1'b0, 1'b1, 16, 3, 1'b1);
        idle(20);

        // False start: 4 clocks low.
        RX_Data = 1'b0;
        repeat (4) tick();
        @(negedge internal_clock);
        chk("false_start_busy", int'(rx_busy), 1);
        idle(48);
        @(negedge internal_clock);
        chk("false_start_idle", int'(rx_busy), 0);

        // Stop bit 0, then line held low three more bit times.
        send_frame(8'h3C, 1'b0, 1'b0, 16, -1, 1'b1);
        RX_Data = 1'b0;
        repeat (48) tick();
        @(negedge internal_clock);
        chk("stuck_low_idle", int'(rx_busy), 0);
        idle(32);
        send_frame(8'h5A, 1'b0, 1'b1, 16, -1, 1'b1);
        idle(20);

        // Overrun: consumer stalls across two frames.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1, 16, -1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 16, -1, 1'b0);
        idle(10);
        @(negedge internal_clock);
        chk("ovr_valid_held", int'(rx_valid), 1);
        chk("ovr_byte_kept", int'(rx_byte), 8'h11);
        chk("ovr_flag_set", int'(rx_overrun), 1);
        tick();
        rx_ready = 1'b1;
        tick();
        @(negedge internal_clock);
        chk("ovr_valid_cleared", int'(rx_valid), 0);
        chk("ovr_flag_cleared", int'(rx_overrun), 0);
        idle(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1, 16, -1, 1'b1);
        idle(10);
        send_frame(8'h07, 1'b1, 1'b1, 16, -1, 1'b1);
        idle(10);
`endif

        // RX_Enable dropped in DATA.
        CLK_PERS_BIT = 18'd16;
        repeat (5) send_bit(1'b0, 16, -1);
        @(negedge internal_clock);
        chk("en_busy_in_data", int'(rx_busy), 1);
        tick();
        RX_Enable = 1'b0;
        tick();
        @(negedge internal_clock);
        chk("en_abort_idle", int'(rx_busy), 0);
        idle(32);
        RX_Enable = 1'b1;
        idle(32);
        @(negedge internal_clock);
        chk("en_no_delivery", int'(rx_valid), 0);

        // rst_n pulsed in DATA with a byte held.
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 16, -1, 1'b0);
        idle(10);
        @(negedge internal_clock);
        chk("rst_pre_valid", int'(rx_valid), 1);
        chk("rst_pre_byte", int'(rx_byte), 8'h33);
        tick();
        repeat (4) send_bit(1'b0, 16, -1);
        rst_n = 1'b0;
        @(negedge internal_clock);
        chk("rst_busy", int'(rx_busy), 0);
        chk("rst_valid", int'(rx_valid), 0);
        chk("rst_byte", int'(rx_byte), 0);
        chk("rst_frame_err", int'(rx_frame_err), 0);
        chk("rst_parity_err", int'(rx_parity_err), 0);
        chk("rst_overrun", int'(rx_overrun), 0);
        tick();
        RX_Data = 1'b1;
        tick();
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        idle(40);

        // Randomized frames: bit period, data, glitches, stop/parity errors,
        // back-to-back spacing.
        for (int n = 0; n < 20; n++) begin
            raw  = int'($urandom_range(0, 40));
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            pbit = 1'($urandom);
            gbit = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
            send_frame(d, pbit, stop, raw, gbit, 1'b1);
            if (!stop) begin
                gap = 40 + int'($urandom_range(0, 10));
            end else begin
                gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
            end
            if (gap > 0) idle(gap);
        end
        idle(20);

        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            tick();
            k++;
        end
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
